ram_arbiter: RTL and testbench

Single-cycle arbiter sharing the one-port system RAM among three requesters: the BIOS loader, the CPU instruction-fetch port and the CPU data port. While the BIOS has not booted the CPU, only the BIOS port is eligible. After boot, only the CPU ports are eligible, and they are arbitrated round-robin or by fixed priority. The block sits between the BIOS/CPU and the RAM macro, returns each read's data to the port that issued it, and supports back-to-back accesses.

---
 rtl/ram_arb_pkg.sv | 14 +
 rtl/ram_arbiter_rr_arb2.sv | 19 +
 rtl/ram_arbiter.sv | 95 +++++++++
 tb/tb_ram_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types for the system RAM arbiter.
//    req_id_t    - identifies a requester (or none) for grants and read return
//    port_req_t  - one port's request fields (we, be, addr, wdata)
package ram_arb_pkg;
   localparam int ARB_AW = 32;
   localparam int ARB_DW = 32;
   typedef enum logic [1:0] {REQ_NONE, REQ_BIOS, REQ_IF, REQ_DS} req_id_t;
   typedef struct packed {
      logic                we;
      logic [ARB_DW/8-1:0] be;
      logic [ARB_AW-1:0]   addr;
      logic [ARB_DW-1:0]   wdata;
   } port_req_t;
endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on a tie the port not granted last wins.
//    clk, rst_n  - clock, asynchronous active-low reset (last grant resets to port 1)
//    req_i[1:0]  - requests (bit 0 = IF, bit 1 = DS in the RAM arbiter)
//    gnt_o[1:0]  - one-hot or zero grants, combinational from req_i and last grant
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);
   logic last_q, last_d;
   assign gnt_o[0] = req_i[0] & (~req_i[1] | last_q);
   assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_q);
   assign last_d   = (|gnt_o) ? gnt_o[1] : last_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= 1'b1;
      else        last_q <= last_d;
   end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the one-port system RAM among BIOS, CPU fetch (if_) and CPU data (ds_).
//    i_booted=0 : only BIOS eligible; i_booted=1 : only IF/DS eligible.
//    Per port P: P_req/we/be/addr/wdata in, P_gnt (same-cycle), P_rvalid/P_rdata (next cycle).
//    RAM side: ram_en/we/be/addr/wdata out, ram_rdata in (one cycle after read strobe).
//    Macro RAM_ARB_RR_EN: round-robin IF/DS; undefined: fixed priority DS over IF.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = ARB_AW,
   parameter int DATA_WIDTH = ARB_DW
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_booted,
   input  logic                    bios_req,
   input  logic                    bios_we,
   input  logic [DATA_WIDTH/8-1:0] bios_be,
   input  logic [ADDR_WIDTH-1:0]   bios_addr,
   input  logic [DATA_WIDTH-1:0]   bios_wdata,
   output logic                    bios_gnt,
   output logic                    bios_rvalid,
   output logic [DATA_WIDTH-1:0]   bios_rdata,
   input  logic                    if_req,
   input  logic                    if_we,
   input  logic [DATA_WIDTH/8-1:0] if_be,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   input  logic [DATA_WIDTH-1:0]   if_wdata,
   output logic                    if_gnt,
   output logic                    if_rvalid,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   input  logic                    ds_req,
   input  logic                    ds_we,
   input  logic [DATA_WIDTH/8-1:0] ds_be,
   input  logic [ADDR_WIDTH-1:0]   ds_addr,
   input  logic [DATA_WIDTH-1:0]   ds_wdata,
   output logic                    ds_gnt,
   output logic                    ds_rvalid,
   output logic [DATA_WIDTH-1:0]   ds_rdata,
   output logic                    ram_en,
   output logic                    ram_we,
   output logic [DATA_WIDTH/8-1:0] ram_be,
   output logic [ADDR_WIDTH-1:0]   ram_addr,
   output logic [DATA_WIDTH-1:0]   ram_wdata,
   input  logic [DATA_WIDTH-1:0]   ram_rdata
);
   port_req_t  bios_r, if_r, ds_r, sel;
   req_id_t    owner_q, owner_d;
   logic       if_ok, ds_ok;
   logic [1:0] cpu_gnt;
   assign bios_r = '{bios_we, bios_be, bios_addr, bios_wdata};
   assign if_r   = '{if_we, if_be, if_addr, if_wdata};
   assign ds_r   = '{ds_we, ds_be, ds_addr, ds_wdata};
   // Grants are forced low while reset is asserted, even with requests held high.
   assign bios_gnt = rst_n & ~i_booted & bios_req;
   assign if_ok    = rst_n & i_booted & if_req;
   assign ds_ok    = rst_n & i_booted & ds_req;
`ifdef RAM_ARB_RR_EN
   rr_arb2 u_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i ({ds_ok, if_ok}),
      .gnt_o (cpu_gnt)
   );
`else
   assign cpu_gnt = {ds_ok, if_ok & ~ds_ok};
`endif
   assign if_gnt = cpu_gnt[0];
   assign ds_gnt = cpu_gnt[1];
   always_comb begin
      sel = '0;
      sel = bios_gnt ? bios_r : ds_gnt ? ds_r : if_gnt ? if_r : '0;
   end
   assign ram_en    = bios_gnt | if_gnt | ds_gnt;
   assign ram_we    = sel.we;
   assign ram_be    = sel.be;
   assign ram_addr  = sel.addr;
   assign ram_wdata = sel.wdata;
   // One-entry return register: owner of the read granted this cycle, if any.
   always_comb begin
      owner_d = REQ_NONE;
      owner_d = (bios_gnt & ~bios_we) ? REQ_BIOS :
                (if_gnt & ~if_we)     ? REQ_IF   :
                (ds_gnt & ~ds_we)     ? REQ_DS   : REQ_NONE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) owner_q <= REQ_NONE;
      else        owner_q <= owner_d;
   end
   assign bios_rvalid = owner_q == REQ_BIOS;
   assign if_rvalid   = owner_q == REQ_IF;
   assign ds_rvalid   = owner_q == REQ_DS;
   assign bios_rdata  = bios_rvalid ? ram_rdata : '0;
   assign if_rdata    = if_rvalid ? ram_rdata : '0;
   assign ds_rdata    = ds_rvalid ? ram_rdata : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed + short random stimulus against a spec-level model, plus literal pins.
module tb_ram_arbiter;
   logic        clk, rst_n, i_booted;
   logic        bios_req, bios_we, if_req, if_we, ds_req, ds_we;
   logic [3:0]  bios_be, if_be, ds_be;
   logic [31:0] bios_addr, if_addr, ds_addr, bios_wdata, if_wdata, ds_wdata;
   logic        bios_gnt, bios_rvalid, if_gnt, if_rvalid, ds_gnt, ds_rvalid;
   logic [31:0] bios_rdata, if_rdata, ds_rdata;
   logic        ram_en, ram_we;
   logic [3:0]  ram_be;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;

   int checks = 0;
   int failures = 0;
   logic [31:0] mem [0:255];

   // model state: ids 0=none 1=bios 2=if 3=ds
   int          m_owner = 0;
   int          m_last = 3;
   logic [31:0] m_data = '0;
   int          e_win = 0;
   logic        e_we;
   logic [3:0]  e_be;
   logic [31:0] e_addr, e_wdata;
   int          eo;
   logic        ir, dr;
   int          seq [4];

   ram_arbiter dut (
      .clk(clk), .rst_n(rst_n), .i_booted(i_booted),
      .bios_req(bios_req), .bios_we(bios_we), .bios_be(bios_be), .bios_addr(bios_addr),
      .bios_wdata(bios_wdata), .bios_gnt(bios_gnt), .bios_rvalid(bios_rvalid), .bios_rdata(bios_rdata),
      .if_req(if_req), .if_we(if_we), .if_be(if_be), .if_addr(if_addr),
      .if_wdata(if_wdata), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ds_req(ds_req), .ds_we(ds_we), .ds_be(ds_be), .ds_addr(ds_addr),
      .ds_wdata(ds_wdata), .ds_gnt(ds_gnt), .ds_rvalid(ds_rvalid), .ds_rdata(ds_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // RAM macro behaviour driven by the DUT's RAM-side outputs
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            for (int b = 0; b < 4; b++)
               if (ram_be[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
         end else ram_rdata <= mem[ram_addr[9:2]];
      end
   end

   // Compare process: expected outputs from the arbitration rules and model state
   always @(negedge clk) begin
      if (!rst_n) e_win = 0;
      else if (!i_booted) e_win = bios_req ? 1 : 0;
      else begin
         ir = if_req;
         dr = ds_req;
`ifdef RAM_ARB_RR_EN
         e_win = (ir && dr) ? ((m_last == 3) ? 2 : 3) : ir ? 2 : dr ? 3 : 0;
`else
         e_win = dr ? 3 : ir ? 2 : 0;
`endif
      end
      e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0;
      if (e_win == 1) begin e_we = bios_we; e_be = bios_be; e_addr = bios_addr; e_wdata = bios_wdata; end
      if (e_win == 2) begin e_we = if_we; e_be = if_be; e_addr = if_addr; e_wdata = if_wdata; end
      if (e_win == 3) begin e_we = ds_we; e_be = ds_be; e_addr = ds_addr; e_wdata = ds_wdata; end
      chk("bios_gnt", bios_gnt, e_win == 1);
      chk("if_gnt", if_gnt, e_win == 2);
      chk("ds_gnt", ds_gnt, e_win == 3);
      chk("ram_en", ram_en, e_win != 0);
      chk("ram_we", ram_we, e_we);
      chk("ram_be", ram_be, e_be);
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_wdata", ram_wdata, e_wdata);
      eo = rst_n ? m_owner : 0;
      chk("bios_rvalid", bios_rvalid, eo == 1);
      chk("if_rvalid", if_rvalid, eo == 2);
      chk("ds_rvalid", ds_rvalid, eo == 3);
      chk("bios_rdata", bios_rdata, (eo == 1) ? m_data : 32'h0);
      chk("if_rdata", if_rdata, (eo == 2) ? m_data : 32'h0);
      chk("ds_rdata", ds_rdata, (eo == 3) ? m_data : 32'h0);
   end

   // Model state update at each rising edge
   always @(posedge clk) begin
      if (!rst_n) begin
         m_owner = 0;
         m_last = 3;
      end else begin
         if (e_win >= 2) m_last = e_win;
         m_owner = (e_win != 0 && !e_we) ? e_win : 0;
         m_data = mem[e_addr[9:2]];
      end
   end

   task automatic idle();
      bios_req = 0; if_req = 0; ds_req = 0;
      bios_we = 0; if_we = 0; ds_we = 0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8] = 32'hDEADBEEF;
      ram_rdata = 32'h0;
      rst_n = 0; i_booted = 0;
      bios_req = 1; if_req = 1; ds_req = 1;
      bios_we = 0; if_we = 0; ds_we = 0;
      bios_be = 4'hF; if_be = 4'hF; ds_be = 4'hF;
      bios_addr = 0; if_addr = 0; ds_addr = 0;
      bios_wdata = 0; if_wdata = 0; ds_wdata = 0;
      #12;
      chk("rst bios_gnt", bios_gnt, 0);
      chk("rst ram_en", ram_en, 0);
      chk("rst ram_addr", ram_addr, 0);
      i_booted = 1;
      #1;
      chk("rst ds_gnt", ds_gnt, 0);
      i_booted = 0;
      tick();
      rst_n = 1; idle();
      tick();
      // pre-boot BIOS write with a competing IF request
      bios_req = 1; bios_we = 1; bios_addr = 32'h10; bios_wdata = 32'hA5; bios_be = 4'h1;
      if_req = 1; if_addr = 32'h10;
      #3;
      chk("boot0 bios_gnt", bios_gnt, 1);
      chk("boot0 if_gnt", if_gnt, 0);
      chk("boot0 ram_we", ram_we, 1);
      chk("boot0 ram_addr", ram_addr, 32'h10);
      chk("boot0 ram_wdata", ram_wdata, 32'hA5);
      tick();
      idle();
      tick();
      // post-boot tie between IF and DS
      i_booted = 1;
      if_req = 1; if_addr = 32'h10; ds_req = 1; ds_addr = 32'h20;
      for (int i = 0; i < 4; i++) begin
         #3;
         seq[i] = ds_gnt ? 3 : if_gnt ? 2 : 0;
         tick();
      end
`ifdef RAM_ARB_RR_EN
      chk("tie seq0", seq[0], 2);
      chk("tie seq1", seq[1], 3);
      chk("tie seq2", seq[2], 2);
      chk("tie seq3", seq[3], 3);
`else
      chk("tie seq0", seq[0], 3);
      chk("tie seq1", seq[1], 3);
      chk("tie seq2", seq[2], 3);
      chk("tie seq3", seq[3], 3);
`endif
      idle();
      tick();
      // DS read return
      ds_req = 1; ds_addr = 32'h20;
      tick();
      idle();
      #3;
      chk("rd ds_rvalid", ds_rvalid, 1);
      chk("rd ds_rdata", ds_rdata, 32'hDEADBEEF);
      chk("rd if_rvalid", if_rvalid, 0);
      tick();
      // IF read followed by a DS write
      if_req = 1; if_addr = 32'h10;
      tick();
      idle();
      ds_req = 1; ds_we = 1; ds_addr = 32'h24; ds_be = 4'hF; ds_wdata = 32'h12345678;
      #3;
      chk("rw if_rvalid", if_rvalid, 1);
      chk("rw if_rdata", if_rdata, 32'hA5);
      chk("rw ram_we", ram_we, 1);
      chk("rw ram_addr", ram_addr, 32'h24);
      tick();
      idle();
      // boot switch with a BIOS read in flight
      i_booted = 0;
      bios_req = 1; bios_we = 0; bios_addr = 32'h20;
      tick();
      i_booted = 1;
      #3;
      chk("sw bios_rvalid", bios_rvalid, 1);
      chk("sw bios_rdata", bios_rdata, 32'hDEADBEEF);
      chk("sw bios_gnt", bios_gnt, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         #3;
         chk("sw bios stall", bios_gnt, 0);
      end
      tick();
      // reset asserted mid-read
      idle();
      if_req = 1; if_addr = 32'h24;
      #3;
      chk("mr if_gnt", if_gnt, 1);
      #3;
      rst_n = 0;
      tick();
      idle();
      #3;
      chk("mr if_rvalid", if_rvalid, 0);
      tick();
      rst_n = 1;
      tick();
      #3;
      chk("mr empty", if_rvalid, 0);
      // short random phase checked by the model
      for (int i = 0; i < 60; i++) begin
         tick();
         if (i % 10 == 0) i_booted = 1'($urandom_range(0, 1));
         bios_req = 1'($urandom_range(0, 1)); bios_we = 1'($urandom_range(0, 1));
         if_req = 1'($urandom_range(0, 1)); if_we = 0;
         ds_req = 1'($urandom_range(0, 1)); ds_we = 1'($urandom_range(0, 1));
         bios_be = 4'($urandom); if_be = 4'($urandom); ds_be = 4'($urandom);
         bios_addr = 32'($urandom_range(0, 63)) << 2;
         if_addr = 32'($urandom_range(0, 63)) << 2;
         ds_addr = 32'($urandom_range(0, 63)) << 2;
         bios_wdata = $urandom; if_wdata = $urandom; ds_wdata = $urandom;
      end
      tick();
      idle();
      tick();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
